// File: rtl/pc_unit.sv
// Program-counter unit for the multi-cycle core.
// Holds the fetch address and selects the next one from the sequential, branch, jump or
// trap-return source. Traps are taken on an external request or on a misaligned target.
// A second fault while in TRAP locks the unit in HALT until reset.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_update,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap_req,
    output logic [XLEN-1:0] curr_addr,
    output logic [XLEN-1:0] old_addr,
    output logic [XLEN-1:0] next_seq_addr,
    output logic [XLEN-1:0] epc,
    output logic [1:0]      trap_cause,
    output logic            in_trap,
    output logic            halted
);

    // pc_src encodings
    localparam logic [1:0] SrcSeq    = 2'd0;
    localparam logic [1:0] SrcBranch = 2'd1;
    localparam logic [1:0] SrcJump   = 2'd2;
    localparam logic [1:0] SrcEpc    = 2'd3;

    // trap_cause encodings
    localparam logic [1:0] CauseNone      = 2'd0;
    localparam logic [1:0] CauseExternal  = 2'd1;
    localparam logic [1:0] CauseMisalign  = 2'd2;

    // Low bits that must be zero in any legal target
    localparam logic [XLEN-1:0] AlignMask = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {
        StRun,
        StTrap,
        StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] curr_q, curr_d;
    logic [XLEN-1:0] old_q, old_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [1:0]      cause_q, cause_d;

    logic [XLEN-1:0] seq_addr;
    logic [XLEN-1:0] candidate;
    logic            cand_misaligned;
    logic            epc_misaligned;

    // Sequential address wraps naturally at 2^XLEN
    assign seq_addr = curr_q + XLEN'(INC);

    // Candidate next PC selected by pc_src
    always_comb begin
        candidate = seq_addr;
        unique case (pc_src)
            SrcSeq:    candidate = seq_addr;
            SrcBranch: candidate = branch_target;
            SrcJump:   candidate = jump_target;
            SrcEpc:    candidate = epc_q;
            default:   candidate = seq_addr;
        endcase
    end

    assign cand_misaligned = |(candidate & AlignMask);
    assign epc_misaligned  = |(epc_q & AlignMask);

    // Next-state logic; priority is trap_req, then misaligned candidate, then normal load
    always_comb begin
        state_d = state_q;
        curr_d  = curr_q;
        old_d   = old_q;
        epc_d   = epc_q;
        cause_d = cause_q;

        case (state_q)
            StRun: begin
                if (trap_req) begin
                    curr_d  = TRAP_VECTOR;
                    epc_d   = curr_q;
                    old_d   = curr_q;
                    cause_d = CauseExternal;
                    state_d = StTrap;
                end else if (pc_update && (pc_src != SrcEpc)) begin
                    if (cand_misaligned) begin
                        curr_d  = TRAP_VECTOR;
                        epc_d   = curr_q;
                        old_d   = curr_q;
                        cause_d = CauseMisalign;
                        state_d = StTrap;
                    end else begin
                        curr_d = candidate;
                        old_d  = curr_q;
                    end
                end
                // pc_src == SrcEpc outside a trap is ignored
            end

            StTrap: begin
                if (trap_req) begin
                    state_d = StHalt;
                end else if (pc_update) begin
                    if (pc_src == SrcEpc) begin
                        if (epc_misaligned) begin
                            state_d = StHalt;
                        end else begin
                            curr_d  = epc_q;
                            old_d   = curr_q;
                            cause_d = CauseNone;
                            state_d = StRun;
                        end
                    end else if (cand_misaligned) begin
                        state_d = StHalt;
                    end else begin
                        // Handler code runs in TRAP; loads behave as in RUN
                        curr_d = candidate;
                        old_d  = curr_q;
                    end
                end
            end

            StHalt: begin
                // Frozen until reset
            end

            default: begin
                state_d = StHalt;
            end
        endcase
    end

    // State and PC registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            curr_q  <= RESET_VECTOR;
            old_q   <= RESET_VECTOR;
            epc_q   <= '0;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            curr_q  <= curr_d;
            old_q   <= old_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign curr_addr     = curr_q;
    assign old_addr      = old_q;
    assign next_seq_addr = seq_addr;
    assign epc           = epc_q;
    assign trap_cause    = cause_q;
    assign in_trap       = (state_q == StTrap);
    assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes hand-computed expected state for each
// cycle, the monitor pops and compares on the falling edge after the update.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        pc_update;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        trap_req;
    logic [31:0] curr_addr;
    logic [31:0] old_addr;
    logic [31:0] next_seq_addr;
    logic [31:0] epc;
    logic [1:0]  trap_cause;
    logic        in_trap;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] curr;
        logic [31:0] old;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        in_trap;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_update     (pc_update),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .trap_req      (trap_req),
        .curr_addr     (curr_addr),
        .old_addr      (old_addr),
        .next_seq_addr (next_seq_addr),
        .epc           (epc),
        .trap_cause    (trap_cause),
        .in_trap       (in_trap),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
        end
    endtask

    // Monitor: outputs are stable on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "curr_addr", curr_addr, e.curr);
            cmp(e.name, "old_addr", old_addr, e.old);
            cmp(e.name, "next_seq_addr", next_seq_addr, e.curr + 32'd4);
            cmp(e.name, "epc", epc, e.epc);
            cmp(e.name, "trap_cause", {30'd0, trap_cause}, {30'd0, e.cause});
            cmp(e.name, "in_trap", {31'd0, in_trap}, {31'd0, e.in_trap});
            cmp(e.name, "halted", {31'd0, halted}, {31'd0, e.halted});
        end
    end

    // Apply one cycle of stimulus and queue the state expected after the next rising edge
    task automatic step(input string name, input logic r, input logic upd, input logic [1:0] src,
                        input logic [31:0] br, input logic [31:0] jmp, input logic trq,
                        input logic [31:0] c, input logic [31:0] o, input logic [31:0] e,
                        input logic [1:0] cause, input logic it, input logic h);
        exp_t x;
        @(negedge clk);
        #1;
        rst           = r;
        pc_update     = upd;
        pc_src        = src;
        branch_target = br;
        jump_target   = jmp;
        trap_req      = trq;
        x.name    = name;
        x.curr    = c;
        x.old     = o;
        x.epc     = e;
        x.cause   = cause;
        x.in_trap = it;
        x.halted  = h;
        exp_q.push_back(x);
    endtask

    initial begin
        int budget;
        rst = 1'b0; pc_update = 1'b0; pc_src = 2'd0;
        branch_target = '0; jump_target = '0; trap_req = 1'b0;

        //   name          rst upd src branch        jump          trq curr          old           epc       cs it h
        step("reset",       0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0,    0, 0, 0);
        step("release",     1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0,    0, 0, 0);
        step("seq1",        1, 1, 0, 32'h0,        32'h0,        0, 32'h4,        32'h0,        32'h0,    0, 0, 0);
        step("seq2",        1, 1, 0, 32'h0,        32'h0,        0, 32'h8,        32'h4,        32'h0,    0, 0, 0);
        step("seq3",        1, 1, 0, 32'h0,        32'h0,        0, 32'hC,        32'h8,        32'h0,    0, 0, 0);
        step("branch",      1, 1, 1, 32'h4444,     32'h0,        0, 32'h4444,     32'hC,        32'h0,    0, 0, 0);
        step("hold1",       1, 0, 1, 32'h9990,     32'h0,        0, 32'h4444,     32'hC,        32'h0,    0, 0, 0);
        step("hold2",       1, 0, 2, 32'h0,        32'h8880,     0, 32'h4444,     32'hC,        32'h0,    0, 0, 0);
        step("misalign",    1, 1, 2, 32'h0,        32'h5556,     0, 32'h100,      32'h4444,     32'h4444, 2, 1, 0);
        step("ret",         1, 1, 3, 32'h0,        32'h0,        0, 32'h4444,     32'h100,      32'h4444, 0, 0, 0);
        step("to20",        1, 1, 1, 32'h20,       32'h0,        0, 32'h20,       32'h4444,     32'h4444, 0, 0, 0);
        step("trap_wins",   1, 1, 1, 32'h40,       32'h0,        1, 32'h100,      32'h20,       32'h20,   1, 1, 0);
        step("double",      1, 0, 0, 32'h0,        32'h0,        1, 32'h100,      32'h20,       32'h20,   1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step("frozen", 1, 1, 2'(i), 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16),
                 1'(i % 2), 32'h100, 32'h20, 32'h20, 1, 0, 1);
        end
        step("rst_halt",    0, 1, 0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        32'h0,    0, 0, 0);
        step("release2",    1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0,    0, 0, 0);
        step("jump_top",    1, 1, 2, 32'h0,        32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0,       32'h0,    0, 0, 0);
        step("wrap",        1, 1, 0, 32'h0,        32'h0,        0, 32'h0,        32'hFFFF_FFFC, 32'h0,   0, 0, 0);
        step("ret_in_run",  1, 1, 3, 32'h0,        32'h0,        0, 32'h0,        32'hFFFF_FFFC, 32'h0,   0, 0, 0);
        step("ext_trap",    1, 0, 0, 32'h0,        32'h0,        1, 32'h100,      32'h0,        32'h0,    1, 1, 0);
        step("trap_load",   1, 1, 1, 32'h200,      32'h0,        0, 32'h200,      32'h100,      32'h0,    1, 1, 0);
        step("trap_misal",  1, 1, 2, 32'h0,        32'h3,        0, 32'h200,      32'h100,      32'h0,    1, 0, 1);
        step("halt_hold",   1, 1, 3, 32'h0,        32'h0,        0, 32'h200,      32'h100,      32'h0,    1, 0, 1);

        // Let the monitor drain the scoreboard within a bounded number of cycles
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multi-cycle core, replacing the single-source PC register. Holds the current fetch address and selects the next one from sequential, branch, jump or trap-return sources. Captures the pre-update PC for the execute stage and handles trap entry and exit with a saved exception PC. A misaligned-target check and a double-fault halt state are included.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 32'h0000_0000, PC value after reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on any trap entry
- INC, 4, sequential increment
- ALIGN_BITS, 2, low address bits that must be zero for a legal target
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- pc_update  in  1  load the next PC this cycle
- pc_src  in  2  0 = sequential, 1 = branch_target, 2 = jump_target, 3 = return (epc)
- branch_target  in  XLEN  branch destination
- jump_target  in  XLEN  jump destination
- trap_req  in  1  external trap request; acts independently of pc_update
- curr_addr  out  XLEN  registered current PC
- old_addr  out  XLEN  PC value before the most recent accepted update
- next_seq_addr  out  XLEN  combinational curr_addr + INC
- epc  out  XLEN  saved exception PC
- trap_cause  out  2  0 = none, 1 = external, 2 = misaligned target; holds until return or reset
- in_trap  out  1  high in the TRAP state
- halted  out  1  high in the HALT state

## Operation
- State machine: RUN, TRAP, HALT.
- Candidate next PC is selected by pc_src. Sequential is curr_addr + INC modulo 2^XLEN, so the top address wraps to the low addresses.
- Priority within a cycle: trap_req, then misaligned candidate, then normal load.
- RUN, trap_req=1:
  - curr_addr <= TRAP_VECTOR, epc <= curr_addr, old_addr <= curr_addr.
  - trap_cause <= 1. Go to TRAP.
  - pc_update and pc_src are ignored that cycle.
- RUN, pc_update=1, pc_src in {0,1,2}, candidate low ALIGN_BITS nonzero:
  - Same as a trap entry, but trap_cause <= 2.
  - The candidate is discarded.
- RUN, pc_update=1, legal candidate: curr_addr <= candidate, old_addr <= curr_addr.
- RUN, pc_update=1, pc_src=3: ignored; no register changes.
- TRAP, pc_update=1, pc_src in {0,1,2}: loads exactly as in RUN.
- TRAP, pc_update=1, pc_src=3:
  - curr_addr <= epc, old_addr <= curr_addr.
  - trap_cause <= 0. Go to RUN.
  - The epc target is also alignment-checked; if misaligned, go to HALT.
- TRAP, trap_req=1 or misaligned candidate: go to HALT.
  - epc, trap_cause and curr_addr are unchanged.
- HALT: every input is ignored and all registers are frozen. Only rst leaves HALT.
- pc_update=0 and trap_req=0: all registers hold.

## Timing
- Reset (rst low, asynchronous):
  - curr_addr = old_addr = RESET_VECTOR, epc = 0, trap_cause = 0.
  - in_trap = 0, halted = 0, state RUN.
- On release, the first update occurs at the first rising edge with rst high.
- Load latency is one cycle: an input sampled at edge N appears on curr_addr after edge N.
- next_seq_addr follows curr_addr combinationally with zero latency.
- in_trap and halted are decoded directly from the state register and change with it.
- Reset asserted mid-operation, including in TRAP or HALT, overrides everything immediately.

## Test plan
- Reset, then pc_update=1, pc_src=0 for 3 cycles -> curr_addr 0x0, 0x4, 0x8, 0xC; old_addr lags by one cycle (0x8 after the last load).
- From curr_addr=0xC: pc_src=1, branch_target=0x4444 -> curr_addr=0x4444, old_addr=0xC. Drop pc_update for 2 cycles -> curr_addr holds 0x4444.
- At curr_addr=0x4444: pc_src=2, jump_target=0x5556 -> curr_addr=0x100, epc=0x4444, trap_cause=2, in_trap=1. Then pc_src=3 -> curr_addr=0x4444, trap_cause=0, in_trap=0.
- At curr_addr=0x20: trap_req=1 together with pc_update=1, pc_src=1 -> trap wins: curr_addr=0x100, epc=0x20, trap_cause=1. A second trap_req in TRAP -> halted=1, curr_addr frozen at 0x100 for 10 cycles despite stimulus. rst low -> curr_addr=0x0, halted=0.
- Load jump_target=0xFFFF_FFFC, then pc_src=0 -> curr_addr wraps to 0x0. pc_src=3 in RUN -> no change.
